mem_wb_pipe_reg: RTL and testbench

- Parametrised MEM->WB pipeline stage register for the lab pipeline CPU.
- Carries NUM_LANES register-writeback lanes per beat through a valid/ready handshake.
- A two-entry skid buffer gives full throughput with a registered in_ready.
- Adds synchronous flush, optional register-zero write squash, and a combinational forwarding lookup into the held writeback beat.

---
 rtl/mem_wb_pkg.sv | 6 +
 rtl/mem_wb_fwd_mux.sv | 24 ++
 rtl/mem_wb_pipe_reg.sv | 93 +++++++++
 tb/tb_mem_wb_pipe_reg.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: shared occupancy encodings and default widths for the MEM->WB stage
package mem_wb_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_t;
  localparam int DATA_WIDTH = 64;
  localparam int REG_ADDR_WIDTH = 3;
endpackage

// File: rtl/mem_wb_fwd_mux.sv
// mem_wb_fwd_mux: one forwarding port, highest-index enabled lane match wins
module mem_wb_fwd_mux #(
  parameter int DATA_WIDTH = mem_wb_pkg::DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = mem_wb_pkg::REG_ADDR_WIDTH,
  parameter int NUM_LANES = 2
) (
  input  logic                                valid,
  input  logic [NUM_LANES-1:0]                en,
  input  logic [NUM_LANES*REG_ADDR_WIDTH-1:0] w_reg,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]     dout,
  input  logic [REG_ADDR_WIDTH-1:0]           raddr,
  output logic                                hit,
  output logic [DATA_WIDTH-1:0]               data
);
  always_comb begin
    hit = 1'b0;
    data = '0;
    for (int l = 0; l < NUM_LANES; l++)
      if (valid && en[l] && w_reg[l*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == raddr) begin
        hit = 1'b1;
        data = dout[l*DATA_WIDTH +: DATA_WIDTH];
      end
  end
endmodule

// File: rtl/mem_wb_pipe_reg.sv
// mem_wb_pipe_reg: MEM->WB skid-buffered stage register with flush, r0 squash and forwarding
module mem_wb_pipe_reg #(
  parameter int DATA_WIDTH = mem_wb_pkg::DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = mem_wb_pkg::REG_ADDR_WIDTH,
  parameter int NUM_LANES = 2,
  parameter int NUM_FWD = 2,
  parameter bit ZERO_REG_SQUASH = 1'b1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                flush,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NUM_LANES-1:0]                in_w_reg_en,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]     in_dout,
  input  logic [NUM_LANES*REG_ADDR_WIDTH-1:0] in_w_reg,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [NUM_LANES-1:0]                out_w_reg_en,
  output logic [NUM_LANES*DATA_WIDTH-1:0]     out_dout,
  output logic [NUM_LANES*REG_ADDR_WIDTH-1:0] out_w_reg,
  input  logic [NUM_FWD*REG_ADDR_WIDTH-1:0]   fwd_raddr,
  output logic [NUM_FWD-1:0]                  fwd_hit,
  output logic [NUM_FWD*DATA_WIDTH-1:0]       fwd_data
);
  import mem_wb_pkg::*;
  occ_t state, state_nxt;
  logic skid_valid;
  logic [NUM_LANES-1:0] main_en, skid_en, cap_en;
  logic [NUM_LANES*DATA_WIDTH-1:0] main_dout, skid_dout;
  logic [NUM_LANES*REG_ADDR_WIDTH-1:0] main_w_reg, skid_w_reg;
  logic in_fire, out_fire, load_main_in, load_skid, load_main_skid;
  assign in_ready = ~reset & (state != FULL);
  assign out_valid = state != EMPTY;
  assign in_fire = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign out_w_reg_en = out_valid ? main_en : '0;
  assign out_dout = main_dout;
  assign out_w_reg = main_w_reg;
  always_comb begin
    cap_en = in_w_reg_en;
    for (int l = 0; l < NUM_LANES; l++)
      if (ZERO_REG_SQUASH && in_w_reg[l*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == '0) cap_en[l] = 1'b0;
  end
  // an out-of-range state code recovers to EMPTY
  always_comb begin
    state_nxt = flush ? EMPTY :
                state == EMPTY ? (in_fire ? ONE : EMPTY) :
                state == ONE ? ((in_fire && !out_fire) ? FULL : (!in_fire && out_fire) ? EMPTY : ONE) :
                state == FULL ? (out_fire ? ONE : FULL) : EMPTY;
    load_main_in = !flush && in_fire && (state == EMPTY || (state == ONE && out_fire));
    load_skid = !flush && in_fire && state == ONE && !out_fire;
    load_main_skid = !flush && state == FULL && out_fire;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
      skid_valid <= 1'b0;
      main_en <= '0;
      main_dout <= '0;
      main_w_reg <= '0;
      skid_en <= '0;
      skid_dout <= '0;
      skid_w_reg <= '0;
    end else begin
      state <= state_nxt;
      skid_valid <= state_nxt == FULL;
      if (load_skid) begin
        skid_en <= cap_en;
        skid_dout <= in_dout;
        skid_w_reg <= in_w_reg;
      end
      if (load_main_in) begin
        main_en <= cap_en;
        main_dout <= in_dout;
        main_w_reg <= in_w_reg;
      end else if (load_main_skid && skid_valid) begin
        main_en <= skid_en;
        main_dout <= skid_dout;
        main_w_reg <= skid_w_reg;
      end
    end
  end
  for (genvar r = 0; r < NUM_FWD; r++) begin : g_fwd
    mem_wb_fwd_mux #(
      .DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH), .NUM_LANES(NUM_LANES)
    ) u_fwd (
      .valid(out_valid), .en(out_w_reg_en), .w_reg(main_w_reg), .dout(main_dout),
      .raddr(fwd_raddr[r*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]),
      .hit(fwd_hit[r]), .data(fwd_data[r*DATA_WIDTH +: DATA_WIDTH])
    );
  end
endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// tb_mem_wb_pipe_reg: directed scenario tasks for the MEM->WB stage register
module tb_mem_wb_pipe_reg;
  logic clk = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [1:0] in_w_reg_en = '0;
  logic [127:0] in_dout = '0;
  logic [5:0] in_w_reg = '0, fwd_raddr = '0;
  logic in_ready, out_valid, in_ready0, out_valid0;
  logic [1:0] out_w_reg_en, fwd_hit, out_w_reg_en0, fwd_hit0;
  logic [127:0] out_dout, fwd_data, out_dout0, fwd_data0;
  logic [5:0] out_w_reg, out_w_reg0;
  int checks = 0, passed = 0;

  mem_wb_pipe_reg dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_w_reg_en(in_w_reg_en), .in_dout(in_dout), .in_w_reg(in_w_reg),
    .out_valid(out_valid), .out_ready(out_ready), .out_w_reg_en(out_w_reg_en),
    .out_dout(out_dout), .out_w_reg(out_w_reg), .fwd_raddr(fwd_raddr),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );
  mem_wb_pipe_reg #(.ZERO_REG_SQUASH(1'b0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_w_reg_en(in_w_reg_en), .in_dout(in_dout), .in_w_reg(in_w_reg),
    .out_valid(out_valid0), .out_ready(out_ready), .out_w_reg_en(out_w_reg_en0),
    .out_dout(out_dout0), .out_w_reg(out_w_reg0), .fwd_raddr(fwd_raddr),
    .fwd_hit(fwd_hit0), .fwd_data(fwd_data0)
  );

  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic v, input logic [1:0] en, input logic [2:0] r0, input logic [2:0] r1,
                      input logic [63:0] d0, input logic [63:0] d1);
    in_valid = v;
    in_w_reg_en = en;
    in_w_reg = {r1, r0};
    in_dout = {d1, d0};
  endtask

  task automatic test_reset();
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %0h exp 0", out_valid); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %0h exp 0", in_ready); else passed++;
    checks++; if (out_w_reg_en !== 2'b00 || out_dout !== '0 || out_w_reg !== '0)
      $display("FAIL rst_payload got en=%0h dout=%0h reg=%0h exp 0", out_w_reg_en, out_dout, out_w_reg); else passed++;
    checks++; if (fwd_hit !== 2'b00 || fwd_data !== '0)
      $display("FAIL rst_fwd got hit=%0h data=%0h exp 0", fwd_hit, fwd_data); else passed++;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL rst_release_ready got %0h exp 1", in_ready); else passed++;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send(1'b1, 2'b01, 3'd3, 3'd0, 64'hAAAA, 64'h0);
    tick();
    checks++; if (out_valid !== 1'b1) $display("FAIL basic_valid got %0h exp 1", out_valid); else passed++;
    checks++; if (out_w_reg_en !== 2'b01) $display("FAIL basic_en got %0h exp 1", out_w_reg_en); else passed++;
    checks++; if (out_dout[63:0] !== 64'hAAAA) $display("FAIL basic_dout got %0h exp aaaa", out_dout[63:0]); else passed++;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 2'b01, 3'd3, 3'd0, 64'hB000 + 64'(i), 64'h0);
      checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready got %0h exp 1", in_ready); else passed++;
      tick();
      checks++; if (out_valid !== 1'b1 || out_dout[63:0] !== 64'hB000 + 64'(i))
        $display("FAIL b2b_beat got v=%0h d=%0h exp v=1 d=%0h", out_valid, out_dout[63:0], 64'hB000 + 64'(i)); else passed++;
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL basic_drain got %0h exp 0", out_valid); else passed++;
  endtask

  task automatic test_full_order();
    out_ready = 1'b0;
    send(1'b1, 2'b01, 3'd1, 3'd0, 64'hA1, 64'h0);
    tick();
    send(1'b1, 2'b01, 3'd1, 3'd0, 64'hB2, 64'h0);
    tick();
    checks++; if (in_ready !== 1'b0) $display("FAIL full_ready got %0h exp 0", in_ready); else passed++;
    checks++; if (out_dout[63:0] !== 64'hA1) $display("FAIL full_head got %0h exp a1", out_dout[63:0]); else passed++;
    send(1'b1, 2'b01, 3'd1, 3'd0, 64'hC3, 64'h0);
    tick();
    checks++; if (in_ready !== 1'b0 || out_dout[63:0] !== 64'hA1)
      $display("FAIL full_hold got r=%0h d=%0h exp r=0 d=a1", in_ready, out_dout[63:0]); else passed++;
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_dout[63:0] !== 64'hB2)
      $display("FAIL order_b got v=%0h d=%0h exp v=1 d=b2", out_valid, out_dout[63:0]); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL order_ready got %0h exp 1", in_ready); else passed++;
    tick();
    checks++; if (out_valid !== 1'b1 || out_dout[63:0] !== 64'hC3)
      $display("FAIL order_c got v=%0h d=%0h exp v=1 d=c3", out_valid, out_dout[63:0]); else passed++;
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL order_drain got %0h exp 0", out_valid); else passed++;
  endtask

  task automatic test_squash();
    out_ready = 1'b1;
    send(1'b1, 2'b11, 3'd0, 3'd5, 64'h11, 64'h22);
    tick();
    checks++; if (out_w_reg_en !== 2'b10) $display("FAIL squash_en got %0h exp 2", out_w_reg_en); else passed++;
    checks++; if (out_w_reg !== {3'd5, 3'd0} || out_dout !== {64'h22, 64'h11})
      $display("FAIL squash_payload got reg=%0h dout=%0h", out_w_reg, out_dout); else passed++;
    checks++; if (out_w_reg_en0 !== 2'b11) $display("FAIL nosquash_en got %0h exp 3", out_w_reg_en0); else passed++;
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_fwd();
    out_ready = 1'b0;
    fwd_raddr = {3'd6, 3'd4};
    send(1'b1, 2'b11, 3'd4, 3'd4, 64'd1, 64'd2);
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (fwd_hit !== 2'b01) $display("FAIL fwd_hit got %0h exp 1", fwd_hit); else passed++;
    checks++; if (fwd_data[63:0] !== 64'd2) $display("FAIL fwd_data0 got %0h exp 2", fwd_data[63:0]); else passed++;
    checks++; if (fwd_data[127:64] !== 64'd0) $display("FAIL fwd_data1 got %0h exp 0", fwd_data[127:64]); else passed++;
    fwd_raddr = {3'd4, 3'd3};
    #1;
    checks++; if (fwd_hit !== 2'b10 || fwd_data[127:64] !== 64'd2 || fwd_data[63:0] !== 64'd0)
      $display("FAIL fwd_swap got hit=%0h data=%0h exp hit=2", fwd_hit, fwd_data); else passed++;
    out_ready = 1'b1;
    tick();
    checks++; if (fwd_hit !== 2'b00 || fwd_data !== '0)
      $display("FAIL fwd_empty got hit=%0h data=%0h exp 0", fwd_hit, fwd_data); else passed++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(1'b1, 2'b01, 3'd2, 3'd0, 64'hA5, 64'h0);
    tick();
    send(1'b1, 2'b01, 3'd2, 3'd0, 64'hB5, 64'h0);
    tick();
    send(1'b1, 2'b01, 3'd2, 3'd0, 64'hDD, 64'h0);
    flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) $display("FAIL flush_full_ready got %0h exp 0", in_ready); else passed++;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_w_reg_en !== 2'b00 || in_ready !== 1'b1)
      $display("FAIL flush_full got v=%0h en=%0h r=%0h exp 0 0 1", out_valid, out_w_reg_en, in_ready); else passed++;
    send(1'b1, 2'b01, 3'd2, 3'd0, 64'hE5, 64'h0);
    tick();
    send(1'b1, 2'b01, 3'd2, 3'd0, 64'hF5, 64'h0);
    flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL flush_one_ready got %0h exp 1", in_ready); else passed++;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL flush_one_valid got %0h exp 0", out_valid); else passed++;
    tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL flush_ghost got %0h exp 0", out_valid); else passed++;
    send(1'b1, 2'b01, 3'd2, 3'd0, 64'h77, 64'h0);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_dout[63:0] !== 64'h77)
      $display("FAIL flush_after got v=%0h d=%0h exp v=1 d=77", out_valid, out_dout[63:0]); else passed++;
    tick();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    fwd_raddr = {3'd0, 3'd3};
    send(1'b1, 2'b01, 3'd3, 3'd0, 64'h91, 64'h0);
    tick();
    send(1'b1, 2'b01, 3'd3, 3'd0, 64'h92, 64'h0);
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (fwd_hit !== 2'b01 || in_ready !== 1'b0)
      $display("FAIL arst_pre got hit=%0h r=%0h exp hit=1 r=0", fwd_hit, in_ready); else passed++;
    #1 reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || fwd_hit !== 2'b00)
      $display("FAIL arst_drop got v=%0h r=%0h hit=%0h exp 0", out_valid, in_ready, fwd_hit); else passed++;
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    send(1'b1, 2'b01, 3'd3, 3'd0, 64'h99, 64'h0);
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL arst_ready got %0h exp 1", in_ready); else passed++;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_dout[63:0] !== 64'h99)
      $display("FAIL arst_first got v=%0h d=%0h exp v=1 d=99", out_valid, out_dout[63:0]); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_order();
    test_squash();
    test_fwd();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
